// File: rtl/io_slot_client_pkg.sv
// Shared definitions for the IO slot client: arbiter direction codes,
// the client FSM state type and the buffered request entry layout.
// Request fields are sized to the widest supported word. Each instance
// zero-extends into the entry and slices back out to its own WORD_SIZE.
package gc;

  localparam logic IO_IN  = 1'b1;
  localparam logic IO_OUT = 1'b0;

  localparam int MAX_WORD_SIZE = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic                     write;
    logic [MAX_WORD_SIZE-1:0] addr;
    logic [MAX_WORD_SIZE-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/io_slot_client_if.sv
// Device-side request/response handshake plus the arbiter slot signals.
// The master modport is the device and arbiter side.
// The slave modport is the io_slot_client side.
interface io_slot_client_if #(
  parameter int WORD_SIZE = 16
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [WORD_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_write;
  logic [WORD_SIZE-1:0] rsp_rdata;

  logic                 slot_valid;
  logic [WORD_SIZE-1:0] arb_addr;
  logic [WORD_SIZE-1:0] arb_wdata;
  logic                 arb_dir;
  logic [WORD_SIZE-1:0] arb_rdata;

  logic                 timeout_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           slot_valid, arb_rdata,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
           arb_addr, arb_wdata, arb_dir, timeout_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           slot_valid, arb_rdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
           arb_addr, arb_wdata, arb_dir, timeout_err
  );

endinterface

// File: rtl/io_req_fifo.sv
// Request buffer for io_slot_client: a FIFO_DEPTH-entry circular FIFO
// with registered occupancy count. Pointers wrap naturally because the
// depth is a power of two. Push while full and pop while empty are ignored.
module io_req_fifo
  import gc::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  req_entry_t                      push_entry,
  input  logic                            pop,
  output req_entry_t                      head,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            full,
  output logic                            empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                 mem_write [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] mem_addr  [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] mem_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = '{write: mem_write[rd_ptr],
                  addr:  MAX_WORD_SIZE'(mem_addr[rd_ptr]),
                  wdata: MAX_WORD_SIZE'(mem_wdata[rd_ptr])};

  // Entry storage: written at the tail on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_write[wr_ptr] <= push_entry.write;
      mem_addr[wr_ptr]  <= push_entry.addr[WORD_SIZE-1:0];
      mem_wdata[wr_ptr] <= push_entry.wdata[WORD_SIZE-1:0];
    end
  end

  // Pointer and count bookkeeping. A simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_slot_client.sv
// IO slot client: buffers device memory requests and presents the oldest
// request to the IO arbiter. It completes that request in the first cycle
// the arbiter grants this client's slot. It then holds one response until
// the device takes it.
// Optional feature macro: IO_CLIENT_TIMEOUT_EN. When defined, this enables a
// sticky watchdog on slot-wait time.
module io_slot_client
  import gc::*;
#(
  parameter int WORD_SIZE      = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  io_slot_client_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t               state;
  req_entry_t           push_entry;
  req_entry_t           head;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 rsp_valid_q;
  logic                 rsp_write_q;
  logic [WORD_SIZE-1:0] rsp_rdata_q;

  assign push = bus.req_valid && !full;
  assign pop  = (state == ST_WAIT) && bus.slot_valid;

  assign push_entry = '{write: bus.req_write,
                        addr:  MAX_WORD_SIZE'(bus.req_addr),
                        wdata: MAX_WORD_SIZE'(bus.req_wdata)};

  io_req_fifo #(
    .WORD_SIZE (WORD_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.req_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Arbiter outputs follow the FIFO head only while waiting for a slot.
  always_comb begin
    bus.arb_addr  = '0;
    bus.arb_wdata = '0;
    bus.arb_dir   = IO_OUT;
    if (state == ST_WAIT) begin
      bus.arb_addr  = head.addr[WORD_SIZE-1:0];
      bus.arb_wdata = head.wdata[WORD_SIZE-1:0];
      bus.arb_dir   = head.write ? IO_IN : IO_OUT;
    end
  end

  // Client FSM: the registered response fields are only updated on a granted slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != '0) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.slot_valid) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= head.write;
            rsp_rdata_q <= head.write ? '0 : bus.arb_rdata;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= (count != '0) ? ST_WAIT : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IO_CLIENT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_count;
  logic            wd_err;

  assign bus.timeout_err = wd_err;

  // Watchdog: counts ungranted WAIT cycles; the error flag stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_count <= '0;
      wd_err   <= 1'b0;
    end else if ((state == ST_WAIT) && !bus.slot_valid) begin
      if (wd_count != WD_W'(TIMEOUT_CYCLES)) wd_count <= wd_count + 1'b1;
      if (wd_count == WD_W'(TIMEOUT_CYCLES - 1)) wd_err <= 1'b1;
    end else begin
      wd_count <= '0;
    end
  end
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_slot_client.sv
// Self-checking bench for io_slot_client. A queue-based reference model
// tracks buffered requests, the held response and slot eligibility.
// Directed scenarios run first, followed by a randomized phase.
// Honours IO_CLIENT_TIMEOUT_EN for the expected timeout_err value.
module tb_io_slot_client;
  import gc::*;

  localparam int W = 16;
  localparam int D = 4;
  localparam int T = 8;

  typedef struct {
    bit           write;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  io_slot_client_if #(.WORD_SIZE(W)) bus ();

  io_slot_client #(
    .WORD_SIZE     (W),
    .FIFO_DEPTH    (D),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  req_t         q[$];
  bit           m_eligible;
  bit           m_held;
  bit           m_rsp_write;
  logic [W-1:0] m_rsp_rdata;
  int           m_wd;
  bit           m_err;

  logic         s_rst, s_valid, s_write, s_rready, s_slot;
  logic [W-1:0] s_addr, s_wdata, s_rdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic w,
                               input logic [W-1:0] a, input logic [W-1:0] d,
                               input logic rr, input logic sl, input logic [W-1:0] rd);
    @(negedge clk);
    s_rst = r; s_valid = v; s_write = w; s_addr = a; s_wdata = d;
    s_rready = rr; s_slot = sl; s_rdata = rd;
    rst            = r;
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.rsp_ready  = rr;
    bus.slot_valid = sl;
    bus.arb_rdata  = rd;
    #1;
  endtask

  task automatic checkOutput();
    logic exp_err;
    check("req_ready", 32'(bus.req_ready), 32'(q.size() < D));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_held));
    if (m_held) begin
      check("rsp_write", 32'(bus.rsp_write), 32'(m_rsp_write));
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rsp_rdata));
    end
    if (m_eligible) begin
      check("arb_dir", 32'(bus.arb_dir), 32'(q[0].write ? IO_IN : IO_OUT));
      check("arb_addr", 32'(bus.arb_addr), 32'(q[0].addr));
      check("arb_wdata", 32'(bus.arb_wdata), 32'(q[0].wdata));
    end else begin
      check("arb_dir_idle", 32'(bus.arb_dir), 32'(IO_OUT));
      check("arb_addr_idle", 32'(bus.arb_addr), 32'(0));
      check("arb_wdata_idle", 32'(bus.arb_wdata), 32'(0));
    end
`ifdef IO_CLIENT_TIMEOUT_EN
    exp_err = m_err;
`else
    exp_err = 1'b0;
`endif
    check("timeout_err", 32'(bus.timeout_err), 32'(exp_err));
  endtask

  // Advance one clock edge and move the reference model with the stimulus driven.
  task automatic tick();
    int   qsize;
    req_t h;
    @(posedge clk);
    if (s_rst) begin
      q.delete();
      m_eligible = 0; m_held = 0; m_wd = 0; m_err = 0;
    end else begin
      qsize = q.size();
      if (m_eligible && !s_slot) begin
        m_wd++;
        if (m_wd >= T) m_err = 1;
      end else begin
        m_wd = 0;
      end
      if (m_eligible && s_slot) begin
        h = q.pop_front();
        m_held      = 1;
        m_rsp_write = h.write;
        m_rsp_rdata = h.write ? '0 : s_rdata;
        m_eligible  = 0;
      end else if (m_held) begin
        if (s_rready) begin
          m_held     = 0;
          m_eligible = (qsize > 0);
        end
      end else if (!m_eligible) begin
        m_eligible = (qsize > 0);
      end
      if (s_valid && qsize < D) q.push_back('{write: s_write, addr: s_addr, wdata: s_wdata});
    end
  endtask

  task automatic step(input logic r, input logic v, input logic w,
                      input logic [W-1:0] a, input logic [W-1:0] d,
                      input logic rr, input logic sl, input logic [W-1:0] rd);
    applyStimulus(r, v, w, a, d, rr, sl, rd);
    checkOutput();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 0; bus.slot_valid = 0; bus.arb_rdata = '0;
    s_rst = 1; s_valid = 0; s_write = 0; s_addr = '0; s_wdata = '0;
    s_rready = 0; s_slot = 0; s_rdata = '0;
    repeat (2) @(posedge clk);
    tick();

    // Write grant: push at cycle 1, slot at cycle 3, response at cycle 4.
    step(0, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h5555);
    check("wr_grant_dir", 32'(bus.arb_dir), 32'(IO_IN));
    check("wr_grant_addr", 32'(bus.arb_addr), 32'h0010);
    check("wr_grant_wdata", 32'(bus.arb_wdata), 32'hBEEF);
    checkOutput();
    tick();
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    check("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("wr_rsp_write", 32'(bus.rsp_write), 32'd1);
    check("wr_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    checkOutput();
    tick();
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);

    // Read grant returns the arbiter read data one cycle after the slot.
    step(0, 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h1234);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    check("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'h1234);
    check("rd_rsp_write", 32'(bus.rsp_write), 32'd0);
    checkOutput();
    tick();
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);

    // Full FIFO: four pushes fill it, and the fifth is refused.
    for (int i = 0; i < 4; i++) step(0, 1, i[0], 16'h0100 + 16'(i), 16'hA000 + 16'(i), 1, 0, 16'h0);
    applyStimulus(0, 1, 1, 16'h0DEAD, 16'h0DEAD, 1, 0, 16'h0);
    check("full_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput();
    tick();
    step(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h7777);
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    check("after_full_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput();
    tick();
    for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h1000 + 16'(i));

    // Response backpressure: a held response blocks further service.
    step(0, 1, 0, 16'h0030, 16'h0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0031, 16'h0, 0, 1, 16'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h2000 + 16'(i));
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h2100);
    check("bp_held_first", 32'(bus.rsp_rdata), 32'h2000);
    checkOutput();
    tick();
    step(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h2200);
    step(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h2300);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    check("bp_second", 32'(bus.rsp_rdata), 32'h2300);
    checkOutput();
    tick();

    // Reset mid-operation discards the queued requests.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 16'h0040 + 16'(i), 16'hC000, 1, 0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_arb_dir", 32'(bus.arb_dir), 32'(IO_OUT));
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput();
    tick();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0);

    // Watchdog: a single request with no slot for longer than the limit.
    step(0, 1, 0, 16'h0050, 16'h0, 1, 0, 16'h0);
    for (int i = 0; i < T + 2; i++) step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
`ifdef IO_CLIENT_TIMEOUT_EN
    check("wd_timeout_set", 32'(bus.timeout_err), 32'd1);
`else
    check("wd_timeout_off", 32'(bus.timeout_err), 32'd0);
`endif
    checkOutput();
    tick();
    step(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(1) == 1), 1'($urandom),
           16'($urandom), 16'($urandom), ($urandom_range(9) < 6),
           ($urandom_range(9) < 4), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_slot_client.md
IO_SLOT_CLIENT -- requirements
Module: io_slot_client

Interface
REQ-001 Parameter WORD_SIZE, default 16, data and address width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, request buffer entries; a power of two, at least 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, slot-wait watchdog limit.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-005 clk  input  1  rising-edge clock shared with the IO arbiter.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  device request present.
REQ-008 req_ready  output  1  request accepted this cycle when req_valid is also high.
REQ-009 req_write  input  1  1 = write to memory, 0 = read from memory.
REQ-010 req_addr  input  WORD_SIZE  memory address.
REQ-011 req_wdata  input  WORD_SIZE  write data.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  device consumes the response.
REQ-014 rsp_write  output  1  response belongs to a write (acknowledge only).
REQ-015 rsp_rdata  output  WORD_SIZE  read data; 0 for write responses.
REQ-016 slot_valid  input  1  this client's arbiter grant for the current cycle.
REQ-017 arb_addr  output  WORD_SIZE  address presented to the arbiter.
REQ-018 arb_wdata  output  WORD_SIZE  write data presented to the arbiter.
REQ-019 arb_dir  output  1  gc::IO_IN for a write, gc::IO_OUT for a read.
REQ-020 arb_rdata  input  WORD_SIZE  memory read data from the arbiter, valid while slot_valid is high.
REQ-021 timeout_err  output  1  sticky watchdog flag.

Function
REQ-022 Requests SHALL enter a FIFO_DEPTH-entry FIFO holding {write, addr, wdata}.
REQ-023 req_ready SHALL equal !full, taken from the registered count; there is no same-cycle push bypass when full.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count runs 0..FIFO_DEPTH.
REQ-025 The FSM SHALL have three states: IDLE (FIFO empty, no response), WAIT (head pending), RESP (response held).
REQ-026 In WAIT, arb_addr, arb_wdata and arb_dir SHALL be driven combinationally from the FIFO head.
REQ-027 In IDLE and RESP, the outputs SHALL be arb_addr=0, arb_wdata=0, arb_dir=gc::IO_OUT.
REQ-028 Service: in WAIT, at the rising edge where slot_valid=1, the block SHALL:
  - pop the head;
  - capture arb_rdata (read) or 0 (write);
  - set rsp_valid=1 from the next cycle;
  - enter RESP.
REQ-029 Latency SHALL be 1 cycle from the granted slot edge to rsp_valid.
REQ-030 In RESP, slot_valid SHALL be ignored; no request is serviced while a response is unconsumed.
REQ-031 RESP exit: on rsp_valid and rsp_ready, go to WAIT if the FIFO is non-empty, else IDLE.
REQ-032 IDLE exit: when count becomes non-zero, go to WAIT on the next cycle.
REQ-033 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-034 rsp_rdata and rsp_write SHALL be held stable while rsp_valid=1.

Reset
REQ-035 Reset SHALL clear:
  - FIFO pointers and count;
  - the FSM (to IDLE);
  - rsp_valid, rsp_write, rsp_rdata;
  - the watchdog counter and timeout_err.
REQ-036 Out of reset, req_ready=1 and all arbiter outputs take their idle values (REQ-027).
REQ-037 Reset mid-operation SHALL discard buffered requests and any held response, with no arbiter write issued.

Configuration
REQ-038 With macro IO_CLIENT_TIMEOUT_EN defined, the watchdog SHALL behave as follows:
  - a counter increments each WAIT cycle with slot_valid=0;
  - it clears on service or on leaving WAIT;
  - reaching TIMEOUT_CYCLES sets timeout_err=1 until rst.
REQ-039 Without IO_CLIENT_TIMEOUT_EN, timeout_err SHALL be constant 0 and no counter logic exists.

Structure
REQ-040 gc SHALL hold IO_IN, IO_OUT, the FSM state enum and the request entry struct.
REQ-041 The FIFO SHALL be a sub-module io_req_fifo (parameters WORD_SIZE, FIFO_DEPTH).

Verification
REQ-042 Write grant: rst, then push write addr=0x0010 data=0xBEEF; pulse slot_valid at cycle 3 -> arb_dir=IO_IN, arb_addr=0x0010 and arb_wdata=0xBEEF during the slot; rsp_valid=1 and rsp_write=1 at cycle 4.
REQ-043 Read grant: push read addr=0x0020; slot_valid with arb_rdata=0x1234 -> rsp_rdata=0x1234 and rsp_write=0 one cycle later.
REQ-044 Full FIFO: 4 pushes with no slot -> req_ready=0; a 5th req_valid is not accepted; after one service plus response consumption -> req_ready=1.
REQ-045 Response backpressure: rsp_ready=0 with 2 queued requests and slot_valid every cycle -> only 1 serviced; the second is serviced at the first slot after rsp_ready=1.
REQ-046 Reset mid-operation: 3 queued requests, assert rst during WAIT -> count=0, rsp_valid=0, arb_dir=IO_OUT the next cycle.
REQ-047 Watchdog: with IO_CLIENT_TIMEOUT_EN, TIMEOUT_CYCLES=8, one request and no slot -> timeout_err=1 after 8 WAIT cycles; without the macro -> timeout_err stays 0.
